// File: rtl/pir_filter_pkg.sv
// pir_filter_pkg: FSM state encoding and default timing constants for pir_filter
package pir_filter_pkg;
  typedef enum logic [2:0] {
    ST_WARMUP  = 3'd0,
    ST_IDLE    = 3'd1,
    ST_QUALIFY = 3'd2,
    ST_ACTIVE  = 3'd3,
    ST_RELEASE = 3'd4,
    ST_LOCKOUT = 3'd5
  } state_t;
  localparam int unsigned DEF_CLK_FREQ       = 50_000_000;
  localparam int unsigned DEF_WARMUP_CYCLES  = 50_000_000;
  localparam int unsigned DEF_QUALIFY_CYCLES = 500_000;
  localparam int unsigned DEF_RELEASE_CYCLES = 2_500_000;
  localparam int unsigned DEF_LOCKOUT_CYCLES = 25_000_000;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for an asynchronous single-bit input
// Ports: clk, reset (async, active-high, clears both flops), d (async in), q (synchronized out)
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic s1_q, s2_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) {s2_q, s1_q} <= 2'b00;
    else       {s2_q, s1_q} <= {s1_q, d};
  assign q = s2_q;
endmodule

// File: rtl/pir_filter.sv
// pir_filter: PIR sensor debounce/qualify FSM with warm-up, release hold-off and lockout
// Ports: clk, reset (async, active-high), sensor_raw (async PIR out),
//        motion (qualified level), motion_rise (onset pulse), ready (warm-up done),
//        event_count (onset count)
// Macro PIR_FILTER_EVENT_CNT_EN: when defined, event_count is a saturating onset counter;
//        otherwise it is tied to zero.
module pir_filter
  import pir_filter_pkg::*;
#(
  parameter int unsigned CLK_FREQ       = DEF_CLK_FREQ,
  parameter int unsigned WARMUP_CYCLES  = DEF_WARMUP_CYCLES,
  parameter int unsigned QUALIFY_CYCLES = DEF_QUALIFY_CYCLES,
  parameter int unsigned RELEASE_CYCLES = DEF_RELEASE_CYCLES,
  parameter int unsigned LOCKOUT_CYCLES = DEF_LOCKOUT_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sensor_raw,
  output logic        motion,
  output logic        motion_rise,
  output logic        ready,
  output logic [15:0] event_count
);
  if (CLK_FREQ < 1 || WARMUP_CYCLES < 1 || QUALIFY_CYCLES < 1 ||
      RELEASE_CYCLES < 1 || LOCKOUT_CYCLES < 1) begin : g_bad_param
    $error("pir_filter: all cycle parameters must be >= 1");
  end
  logic s2;
  sync_2ff u_sync (.clk(clk), .reset(reset), .d(sensor_raw), .q(s2));
  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic        motion_q, motion_d, rise_q, rise_d, ready_q, ready_d;
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + 32'd1;
    motion_d = motion_q;
    rise_d   = 1'b0;
    ready_d  = ready_q;
    case (state_q)
      ST_WARMUP:
        if (cnt_q == WARMUP_CYCLES - 1) begin
          state_d = ST_IDLE;
          ready_d = 1'b1;
          cnt_d   = '0;
        end
      ST_IDLE: begin
        cnt_d   = '0;
        state_d = s2 ? ST_QUALIFY : ST_IDLE;
      end
      ST_QUALIFY:
        if (!s2) state_d = ST_IDLE;
        else if (cnt_q == QUALIFY_CYCLES - 1) begin
          state_d  = ST_ACTIVE;
          motion_d = 1'b1;
          rise_d   = 1'b1;
        end
      ST_ACTIVE: begin
        cnt_d   = '0;
        state_d = s2 ? ST_ACTIVE : ST_RELEASE;
      end
      ST_RELEASE:
        if (s2) state_d = ST_ACTIVE;
        else if (cnt_q == RELEASE_CYCLES - 1) begin
          state_d  = ST_LOCKOUT;
          motion_d = 1'b0;
          cnt_d    = '0;
        end
      ST_LOCKOUT:
        if (cnt_q == LOCKOUT_CYCLES - 1) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      default: begin
        state_d = ST_WARMUP;
        cnt_d   = '0;
      end
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q  <= ST_WARMUP;
      cnt_q    <= '0;
      motion_q <= 1'b0;
      rise_q   <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      motion_q <= motion_d;
      rise_q   <= rise_d;
      ready_q  <= ready_d;
    end
  assign motion      = motion_q;
  assign motion_rise = rise_q;
  assign ready       = ready_q;
`ifdef PIR_FILTER_EVENT_CNT_EN
  logic [15:0] event_count_q, event_count_d;
  // counts together with the registered rise pulse; holds at all-ones
  always_comb event_count_d = event_count_q + 16'(rise_d && event_count_q != 16'hFFFF);
  always_ff @(posedge clk or posedge reset)
    if (reset) event_count_q <= '0;
    else       event_count_q <= event_count_d;
  assign event_count = event_count_q;
`else
  assign event_count = 16'h0000;
`endif
endmodule

// File: tb/tb_pir_filter.sv
// tb_pir_filter: scoreboard bench for pir_filter against a deadline-based reference model
module tb_pir_filter;
  localparam int W = 8, Q = 4, R = 6, L = 10;
  logic clk = 1'b0, reset = 1'b1, sensor_raw = 1'b0;
  logic motion, motion_rise, ready;
  logic [15:0] event_count;
  always #5 clk = ~clk;
  pir_filter #(
    .WARMUP_CYCLES(W), .QUALIFY_CYCLES(Q), .RELEASE_CYCLES(R), .LOCKOUT_CYCLES(L)
  ) dut (
    .clk(clk), .reset(reset), .sensor_raw(sensor_raw),
    .motion(motion), .motion_rise(motion_rise), .ready(ready), .event_count(event_count)
  );
  typedef struct packed {
    logic        motion;
    logic        rise;
    logic        ready;
    logic [15:0] cnt;
  } exp_t;
  exp_t sb[$];
  int tests = 0, fails = 0;
  // reference: mode 0 warm-up, 1 waiting, 2 qualifying, 3 moving, 4 releasing, 5 locked out;
  // each timed mode ends at an absolute edge number t0 + duration
  int   mode, k, t0;
  logic p1, p2;
  exp_t m;
  task automatic model_reset();
    mode = 0; k = 0; t0 = 0; p1 = 1'b0; p2 = 1'b0; m = '0;
  endtask
  task automatic model_step(input logic raw);
    logic s;
    s = p2;
    k++;
    m.rise = 1'b0;
    case (mode)
      0: if (k == W) begin mode = 1; m.ready = 1'b1; end
      1: if (s) begin mode = 2; t0 = k; end
      2: if (!s) mode = 1;
         else if (k == t0 + Q) begin
           mode = 3; m.motion = 1'b1; m.rise = 1'b1;
`ifdef PIR_FILTER_EVENT_CNT_EN
           if (m.cnt != 16'hFFFF) m.cnt = m.cnt + 16'd1;
`endif
         end
      3: if (!s) begin mode = 4; t0 = k; end
      4: if (s) mode = 3;
         else if (k == t0 + R) begin mode = 5; t0 = k; m.motion = 1'b0; end
      5: if (k == t0 + L) mode = 1;
      default: mode = 0;
    endcase
    p2 = p1;
    p1 = raw;
  endtask
  // called just after a falling edge; sets the input for the next rising edge
  task automatic drive(input logic v, input int n);
    repeat (n) begin
      sensor_raw = v;
      model_step(v);
      sb.push_back(m);
      @(negedge clk);
    end
  endtask
  task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s got=%h want=%h at %0t", name, got, want, $time);
    end
  endtask
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (!reset && sb.size() > 0) begin
      e = sb.pop_front();
      tests++;
      if ({motion, motion_rise, ready, event_count} !== e) begin
        fails++;
        $display("FAIL outputs at %0t got motion=%b rise=%b ready=%b count=%h want motion=%b rise=%b ready=%b count=%h",
                 $time, motion, motion_rise, ready, event_count, e.motion, e.rise, e.ready, e.cnt);
      end
    end
  end
  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end
  initial begin
    int guard;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check("reset_motion", {15'd0, motion}, 16'd0);
    check("reset_ready", {15'd0, ready}, 16'd0);
    check("reset_count", event_count, 16'd0);
    reset = 1'b0;
    drive(1'b1, 20);
    drive(1'b0, 20);
    drive(1'b1, 3);
    drive(1'b0, 10);
    check("glitch_count", event_count, m.cnt);
    drive(1'b1, 10);
    drive(1'b0, 4);
    drive(1'b1, 5);
    drive(1'b0, 8);
    drive(1'b1, 25);
    drive(1'b0, 25);
    check("retrigger_count", event_count, m.cnt);
    repeat (40) drive(1'($urandom_range(0, 1)), int'($urandom_range(1, 12)));
    guard = 0;
    while (mode != 3 && guard < 100) begin
      drive(1'b1, 1);
      guard++;
    end
    check("reach_active", 16'(mode), 16'd3);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("async_motion", {15'd0, motion}, 16'd0);
    check("async_ready", {15'd0, ready}, 16'd0);
    check("async_count", event_count, 16'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    drive(1'b1, 20);
    drive(1'b0, 30);
`ifdef PIR_FILTER_EVENT_CNT_EN
    force dut.event_count_q = 16'hFFFE;
    m.cnt = 16'hFFFE;
    drive(1'b0, 2);
    release dut.event_count_q;
    drive(1'b1, 12);
    drive(1'b0, R + L + 5);
    drive(1'b1, 12);
    drive(1'b0, 5);
    check("saturate", event_count, 16'hFFFF);
`else
    drive(1'b1, 12);
    drive(1'b0, 5);
    check("count_tied", event_count, 16'h0000);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
